// File: rtl/timbre_voice_scheduler.sv
// timbre_voice_scheduler: time-shares one timbre lookup across voices and mixes one saturated sample per tick
module timbre_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_sample_tick,
  input  logic                      i_key_valid,
  output logic                      o_key_ready,
  input  logic                      i_key_on,
  input  logic [6:0]                i_key_id,
  input  logic [PHASE_W-1:0]        i_key_inc,
  output logic [5:0]                o_ramp,
  input  logic signed [15:0]        i_timbre,
  output logic signed [15:0]        o_sample,
  output logic                      o_sample_valid,
  output logic [NUM_VOICES-1:0]     o_voice_active,
  output logic                      o_drop,
  output logic                      o_overrun
);
  localparam int KW = $clog2(NUM_VOICES);
  localparam int AW = 16 + KW;
  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic signed [AW-1:0] acc, acc_next;
  logic signed [15:0] sat;
  logic [PHASE_W-1:0] phase [NUM_VOICES];
  logic [PHASE_W-1:0] inc [NUM_VOICES];
  logic [6:0] key [NUM_VOICES];
  logic hit, free, accept;
  logic [KW-1:0] hit_v, free_v;
  // Descending scan so the lowest-index match/free voice wins
  always_comb begin
    hit = 1'b0;
    free = 1'b0;
    hit_v = '0;
    free_v = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (o_voice_active[i] && key[i] == i_key_id) begin
        hit = 1'b1;
        hit_v = KW'(i);
      end
      if (!o_voice_active[i]) begin
        free = 1'b1;
        free_v = KW'(i);
      end
    end
  end
  assign accept = i_key_valid && o_key_ready;
  assign o_ramp = state == SCAN ? phase[k][PHASE_W-1 -: 6] : 6'd0;
  assign acc_next = acc + (o_voice_active[k] ? {{KW{i_timbre[15]}}, i_timbre} : '0);
  assign sat = acc_next > AW'(32767) ? 16'sh7FFF : acc_next < AW'(-32768) ? 16'sh8000 : acc_next[15:0];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      k <= '0;
      acc <= '0;
      o_key_ready <= 1'b1;
      o_sample <= '0;
      o_sample_valid <= 1'b0;
      o_voice_active <= '0;
      o_drop <= 1'b0;
      o_overrun <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        inc[i] <= '0;
        key[i] <= '0;
      end
    end else begin
      o_sample_valid <= 1'b0;
      o_drop <= 1'b0;
      o_overrun <= i_sample_tick && state != IDLE;
      case (state)
        IDLE: begin
          if (accept && i_key_on && hit) begin
            phase[hit_v] <= '0;
            inc[hit_v] <= i_key_inc;
          end else if (accept && i_key_on && free) begin
            o_voice_active[free_v] <= 1'b1;
            key[free_v] <= i_key_id;
            inc[free_v] <= i_key_inc;
            phase[free_v] <= '0;
          end else if (accept && i_key_on) begin
            o_drop <= 1'b1;
          end else if (accept && hit) begin
            o_voice_active[hit_v] <= 1'b0;
            phase[hit_v] <= '0;
          end
          if (i_sample_tick) begin
            state <= SCAN;
            k <= '0;
            acc <= '0;
            o_key_ready <= 1'b0;
          end
        end
        SCAN: begin
          acc <= acc_next;
          if (o_voice_active[k]) phase[k] <= phase[k] + inc[k];
          if (k == KW'(NUM_VOICES - 1)) begin
            state <= OUT;
            o_sample <= sat;
            o_sample_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          o_key_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
